// File: rtl/irq_ctrl_pkg.sv
// Shared types and helpers for the external-interrupt source controller.
package irq_ctrl_pkg;

  // Sequencer state encodings (kept fixed so software/debug views stay stable).
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_SVC  = 2'd2
  } irq_state_e;

  // Widest source vector the controller supports.
  localparam int MAX_SRC = 8;

  // Index of the lowest set bit (index 0 has the highest priority).
  // Returns 0 for an all-zero vector; callers only use it when something is set.
  function automatic int lowest_set(input logic [MAX_SRC-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_ctrl_debounce.sv
// Per-source input conditioning: synchroniser chain, debounce counter,
// accepted level and a one-cycle pulse on each accepted 0->1 transition.
module irq_ctrl_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  output logic rise_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;

  assign sample = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;

  // Shift the raw input through the synchroniser flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
  end

  // Count consecutive samples that disagree with the accepted level; the
  // DEB_CYCLES-th such sample flips the level. Any agreeing sample restarts.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sample == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
      level_d = sample;
      cnt_d   = '0;
      rise_d  = sample;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// External-interrupt source controller feeding cp0 ir_in: debounced edge
// capture into pending bits, masking, fixed priority and a one-at-a-time
// request/acknowledge/ERET sequencer.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int N_SRC       = 4,
  parameter  int DEB_CYCLES  = 16,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             irq_ack,
  input  logic             eret,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic             in_service
);

  logic [N_SRC-1:0]   rise_vec;
  logic [N_SRC-1:0]   pending_q, pending_d;
  logic [N_SRC-1:0]   mask_q, mask_d;
  logic [N_SRC-1:0]   req_vec;
  logic [N_SRC-1:0]   clr_vec;
  logic [MAX_SRC-1:0] req_ext;
  irq_state_e         state_q, state_d;
  logic [ID_W-1:0]    irq_id_q, irq_id_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    irq_ctrl_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .src_i  (src_in[g]),
      .rise_o (rise_vec[g])
    );
  end

  assign req_vec = pending_q & mask_q;
  assign req_ext = MAX_SRC'(req_vec);

  // Next-state and pending-clear decode for the request sequencer.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr_vec  = '0;
    unique case (state_q)
      IRQ_IDLE: begin
        if (|req_vec) begin
          irq_id_d = ID_W'(lowest_set(req_ext));
          state_d  = IRQ_REQ;
        end
      end
      IRQ_REQ: begin
        // An ack wins over a same-cycle mask drop: CP0 already took the jump.
        if (irq_ack) begin
          clr_vec[irq_id_q] = 1'b1;
          state_d           = IRQ_SVC;
        end else if (!mask_q[irq_id_q]) begin
          state_d = IRQ_IDLE;
        end
      end
      IRQ_SVC: begin
        if (eret) state_d = IRQ_IDLE;
      end
      default: state_d = IRQ_IDLE;
    endcase
  end

  // A new rise in the same cycle as the acknowledge clear re-sets the bit.
  assign pending_d = (pending_q & ~clr_vec) | rise_vec;
  assign mask_d    = mask_we ? mask_wdata : mask_q;

  // Sequencer, pending and mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IRQ_IDLE;
      irq_id_q  <= '0;
      pending_q <= '0;
      mask_q    <= '1;
    end else begin
      state_q   <= state_d;
      irq_id_q  <= irq_id_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  assign irq_req    = (state_q == IRQ_REQ);
  assign in_service = (state_q == IRQ_SVC);
  assign irq_id     = irq_id_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl (N_SRC=4, DEB_CYCLES=16, SYNC_STAGES=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       irq_ack;
  logic       eret;
  logic       irq_req;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  irq_ctrl #(
    .N_SRC       (4),
    .DEB_CYCLES  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_in     (src_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq_ack    (irq_ack),
    .eret       (eret),
    .irq_req    (irq_req),
    .irq_id     (irq_id),
    .pending    (pending),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic req, input logic [1:0] id,
                         input logic [3:0] pend, input logic svc);
    chk({tag, "_req"}, 32'(irq_req), 32'(req));
    chk({tag, "_id"}, 32'(irq_id), 32'(id));
    chk({tag, "_pend"}, 32'(pending), 32'(pend));
    chk({tag, "_svc"}, 32'(in_service), 32'(svc));
  endtask

  task automatic pulse_ack;
    irq_ack = 1'b1; step(1); irq_ack = 1'b0;
  endtask

  task automatic pulse_eret;
    eret = 1'b1; step(1); eret = 1'b0;
  endtask

  initial begin
    rst = 1'b1; src_in = 4'b0000; mask_we = 1'b0; mask_wdata = 4'b0000;
    irq_ack = 1'b0; eret = 1'b0;
    step(2);
    chk_all("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    rst = 1'b0;

    // 1: debounced rise on src 2 -> pending after 19 edges, request one later.
    src_in[2] = 1'b1;
    step(18);
    chk("t1_pend_edge18", 32'(pending), 32'h0);
    step(1);
    chk("t1_pend_edge19", 32'(pending), 32'h4);
    chk("t1_req_edge19", 32'(irq_req), 32'h0);
    step(1);
    chk_all("t1_req", 1'b1, 2'd2, 4'b0100, 1'b0);
    step(20);
    chk("t1_req_held", 32'(irq_req), 32'h1);
    pulse_ack();
    chk_all("t1_ack", 1'b0, 2'd2, 4'b0000, 1'b1);
    pulse_eret();
    chk_all("t1_eret", 1'b0, 2'd2, 4'b0000, 1'b0);
    src_in[2] = 1'b0;

    // 2: 8-cycle glitch on src 1 is rejected.
    src_in[1] = 1'b1;
    step(8);
    src_in[1] = 1'b0;
    step(30);
    chk("t2_pend", 32'(pending), 32'h0);
    chk("t2_req", 32'(irq_req), 32'h0);

    // ack and eret while idle: no effect.
    irq_ack = 1'b1; eret = 1'b1;
    step(1);
    irq_ack = 1'b0; eret = 1'b0;
    chk_all("idle_ack_eret", 1'b0, 2'd2, 4'b0000, 1'b0);

    // 3: pending 1010 -> id 1 first, then id 3 after a low gap.
    src_in[1] = 1'b1; src_in[3] = 1'b1;
    step(19);
    chk("t3_pend", 32'(pending), 32'hA);
    step(1);
    chk_all("t3_req1", 1'b1, 2'd1, 4'b1010, 1'b0);
    pulse_ack();
    chk_all("t3_ack1", 1'b0, 2'd1, 4'b1000, 1'b1);
    pulse_eret();
    chk_all("t3_gap", 1'b0, 2'd1, 4'b1000, 1'b0);
    step(1);
    chk_all("t3_req3", 1'b1, 2'd3, 4'b1000, 1'b0);
    pulse_ack();
    chk_all("t3_ack3", 1'b0, 2'd3, 4'b0000, 1'b1);
    pulse_eret();
    src_in[1] = 1'b0; src_in[3] = 1'b0;
    step(20);
    chk_all("t3_quiet", 1'b0, 2'd3, 4'b0000, 1'b0);

    // 4: masking src 0 during its request withdraws it; src 2 goes next.
    src_in[0] = 1'b1; src_in[2] = 1'b1;
    step(20);
    chk_all("t4_req0", 1'b1, 2'd0, 4'b0101, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b1110;
    step(1);
    mask_we = 1'b0;
    chk("t4_req_mask_wr", 32'(irq_req), 32'h1);
    step(1);
    chk_all("t4_withdraw", 1'b0, 2'd0, 4'b0101, 1'b0);
    step(1);
    chk_all("t4_req2", 1'b1, 2'd2, 4'b0101, 1'b0);
    pulse_ack();
    chk_all("t4_ack2", 1'b0, 2'd2, 4'b0001, 1'b1);
    pulse_eret();
    step(2);
    chk_all("t4_masked", 1'b0, 2'd2, 4'b0001, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step(1);
    mask_we = 1'b0;
    step(1);
    chk_all("t4_unmask", 1'b1, 2'd0, 4'b0001, 1'b0);

    // 5: new rise on src 0 in the very cycle it is acknowledged.
    src_in[0] = 1'b0;
    step(20);
    chk("t5_still_req", 32'(irq_req), 32'h1);
    src_in[0] = 1'b1;
    step(18);
    pulse_ack();
    chk_all("t5_ack_set", 1'b0, 2'd0, 4'b0001, 1'b1);
    pulse_eret();
    chk("t5_gap", 32'(irq_req), 32'h0);
    step(1);
    chk_all("t5_rereq", 1'b1, 2'd0, 4'b0001, 1'b0);

    // 6: asynchronous reset mid-request.
    #2;
    rst = 1'b1;
    #1;
    chk_all("t6_async", 1'b0, 2'd0, 4'b0000, 1'b0);
    step(1);
    rst = 1'b0;
    // Debouncers restart from level 0, so the still-high inputs re-qualify.
    step(18);
    chk("t6_pend_edge18", 32'(pending), 32'h0);
    step(1);
    chk("t6_pend_edge19", 32'(pending), 32'h5);
    step(1);
    chk_all("t6_req", 1'b1, 2'd0, 4'b0101, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
